// File: rtl/sha256_sched_pkg.sv
// Shared constants and state encoding for the SHA-256 block scheduler.
// The ERR state exists only when SHA256_SCHED_WDOG_EN is defined.
package sha256_sched_pkg;

    localparam logic [255:0] SHA256_IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BLK,
        KICK,
        RUN,
        DONE
`ifdef SHA256_SCHED_WDOG_EN
        ,
        ERR
`endif
    } state_t;

endpackage

// File: rtl/sha256_sched.sv
// SHA-256 message scheduler: feeds blocks and chaining value to an external core.
// Optional watchdog on the core result is enabled with SHA256_SCHED_WDOG_EN.
module sha256_sched
    import sha256_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 80
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_last,
    output logic [255:0] core_H_in,
    output logic [511:0] core_M_in,
    output logic         core_input_valid,
    input  logic [255:0] core_H_out,
    input  logic         core_output_valid,
    output logic [255:0] digest,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic         busy,
    output logic         err
);

    state_t         state;
    state_t         state_n;
    logic [255:0]   H_reg;
    logic [511:0]   M_reg;
    logic           last_reg;
    logic [15:0]    blk_cnt;

`ifdef SHA256_SCHED_WDOG_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDOG_W-1:0] wdog_cnt;
    logic              wdog_hit;

    assign wdog_hit = (wdog_cnt == WDOG_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
        end else if (state == KICK) begin
            wdog_cnt <= '0;
        end else if (state == RUN) begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end
`endif

    assign core_H_in = H_reg;
    assign core_M_in = M_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            H_reg    <= '0;
            M_reg    <= '0;
            last_reg <= 1'b0;
            blk_cnt  <= '0;
            digest   <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (start) begin
                    H_reg   <= SHA256_IV;
                    blk_cnt <= '0;
                end
                WAIT_BLK: if (blk_valid) begin
                    M_reg    <= blk_data;
                    last_reg <= blk_last;
                end
                RUN: if (core_output_valid) begin
                    H_reg   <= core_H_out;
                    blk_cnt <= blk_cnt + 16'd1;
                    // digest mirrors H_reg on entry to DONE and then holds
                    if (last_reg) digest <= core_H_out;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n          = state;
        blk_ready        = 1'b0;
        core_input_valid = 1'b0;
        case (state)
            IDLE:     if (start) state_n = WAIT_BLK;
            WAIT_BLK: begin
                blk_ready = 1'b1;
                if (blk_valid) state_n = KICK;
            end
            KICK: begin
                core_input_valid = 1'b1;
                state_n          = RUN;
            end
            RUN: begin
                if (core_output_valid) state_n = last_reg ? DONE : WAIT_BLK;
`ifdef SHA256_SCHED_WDOG_EN
                else if (wdog_hit) state_n = ERR;
`endif
            end
            DONE:     if (digest_ready) state_n = IDLE;
            default:  state_n = state;
        endcase
    end

    assign digest_valid = (state == DONE);
    assign busy         = (state != IDLE);
`ifdef SHA256_SCHED_WDOG_EN
    assign err          = (state == ERR);
`else
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_sched.sv
// Self-checking bench for sha256_sched; the bench also plays the SHA-256 core,
// answering each kick with a result pulse 65 cycles later.
module tb_sha256_sched;

    localparam logic [255:0] IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'd0, 32'h00000018};
    localparam logic [255:0] ABC_DIG =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [511:0] TWO_B1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_B2 = {480'd0, 32'h000001c0};
    localparam logic [255:0] TWO_DIG =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         blk_valid = 1'b0;
    logic         blk_ready;
    logic [511:0] blk_data = '0;
    logic         blk_last = 1'b0;
    logic [255:0] core_H_in;
    logic [511:0] core_M_in;
    logic         core_input_valid;
    logic [255:0] core_H_out;
    logic         core_output_valid;
    logic [255:0] digest;
    logic         digest_valid;
    logic         digest_ready = 1'b0;
    logic         busy;
    logic         err;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc = 0;

    // core model state
    logic         model_cov = 1'b0;
    logic [255:0] model_h = '0;
    logic         force_cov = 1'b0;
    logic [255:0] force_h = '0;
    logic         core_en = 1'b1;
    logic         pend = 1'b0;
    logic         abandoned = 1'b0;
    int unsigned  core_cnt = 0;
    int unsigned  kicks = 0;
    int unsigned  kick_cyc = 0;
    logic [255:0] lat_h = '0;
    logic [511:0] lat_m = '0;

    // run_message results
    logic [255:0] r_digest;
    bit           r_ok, r_busy_ok, r_stable_ok;
    int unsigned  r_done_cyc;
    int unsigned  acc_q [$];

    assign core_output_valid = model_cov | force_cov;
    assign core_H_out        = force_cov ? force_h : model_h;

    sha256_sched #(.TIMEOUT_CYCLES(80)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last),
        .core_H_in(core_H_in), .core_M_in(core_M_in), .core_input_valid(core_input_valid),
        .core_H_out(core_H_out), .core_output_valid(core_output_valid),
        .digest(digest), .digest_valid(digest_valid), .digest_ready(digest_ready),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] m);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = m[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    // Core stand-in: result pulse is sampled by the DUT 65 edges after the kick edge.
    always @(negedge clk) begin
        model_cov = 1'b0;
        if (pend && core_en) begin
            if (core_cnt == 1) begin
                model_cov = 1'b1;
                pend = 1'b0;
                if (!abandoned) begin
                    tests++;
                    if (core_H_in !== lat_h || core_M_in !== lat_m) begin
                        fails++;
                        $display("FAIL core_inputs_held: H_in=%h expected %h (M_in match=%0b)",
                                 core_H_in, lat_h, core_M_in === lat_m);
                    end
                end
            end else begin
                core_cnt--;
            end
        end
        if (core_input_valid === 1'b1) begin
            lat_h = core_H_in;
            lat_m = core_M_in;
            model_h = compress(core_H_in, core_M_in);
            core_cnt = 65;
            pend = 1'b1;
            abandoned = 1'b0;
            kicks++;
            kick_cyc = cyc;
        end
    end

    task automatic run_message(input logic [511:0] blks [$], input int gap, input int hold);
        bit got;
        r_ok = 1; r_busy_ok = 1; r_stable_ok = 1;
        acc_q.delete();
        start = 1'b1; @(negedge clk); start = 1'b0;
        foreach (blks[i]) begin
            if (i > 0) repeat (gap) begin
                @(negedge clk);
                if (busy !== 1'b1) r_busy_ok = 0;
            end
            blk_data = blks[i];
            blk_last = (i == blks.size() - 1);
            blk_valid = 1'b1;
            got = 0;
            for (int t = 0; t < 300 && !got; t++) begin
                if (blk_ready === 1'b1) got = 1;
                @(negedge clk);
                if (busy !== 1'b1) r_busy_ok = 0;
            end
            blk_valid = 1'b0;
            blk_last = 1'b0;
            if (!got) r_ok = 0;
            else acc_q.push_back(cyc);
        end
        got = 0;
        for (int t = 0; t < 300 && !got; t++) begin
            if (digest_valid === 1'b1) got = 1;
            else begin
                @(negedge clk);
                if (busy !== 1'b1) r_busy_ok = 0;
            end
        end
        if (!got) r_ok = 0;
        r_done_cyc = cyc;
        r_digest = digest;
        repeat (hold) begin
            @(negedge clk);
            if (digest !== r_digest || digest_valid !== 1'b1 || busy !== 1'b1) r_stable_ok = 0;
        end
        digest_ready = 1'b1; @(negedge clk); digest_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({blk_ready, core_H_in, core_M_in, core_input_valid, digest, digest_valid, busy, err} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%0b blk_ready=%0b digest=%h, all required 0", busy, blk_ready, digest);
        end
        tests++;
        if (dut.H_reg !== '0 || dut.blk_cnt !== 16'd0) begin
            fails++;
            $display("FAIL reset_regs: H_reg=%h blk_cnt=%0d, required 0", dut.H_reg, dut.blk_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_abc();
        logic [511:0] q [$];
        int unsigned k0 = kicks;
        q.push_back(ABC_BLK);
        run_message(q, 0, 0);
        tests++;
        if (r_ok !== 1'b1 || r_digest !== ABC_DIG) begin
            fails++;
            $display("FAIL abc_digest: got %h expected %h (handshake ok=%0b)", r_digest, ABC_DIG, r_ok);
        end
        // accept edge + KICK edge + 65-cycle core -> DONE visible 66 edges after accept
        tests++;
        if (acc_q.size() != 1 || r_done_cyc - acc_q[0] != 66) begin
            fails++;
            $display("FAIL abc_latency: got %0d edges, expected 66", (acc_q.size() > 0) ? r_done_cyc - acc_q[0] : 0);
        end
        tests++;
        if (kicks - k0 != 1 || dut.blk_cnt !== 16'd1) begin
            fails++;
            $display("FAIL abc_counts: kicks=%0d blk_cnt=%0d, expected 1 and 1", kicks - k0, dut.blk_cnt);
        end
        tests++;
        if (digest_valid !== 1'b0 || busy !== 1'b0 || digest !== ABC_DIG) begin
            fails++;
            $display("FAIL abc_after_ready: dv=%0b busy=%0b digest=%h, expected 0 0 %h", digest_valid, busy, digest, ABC_DIG);
        end
    endtask

    task automatic test_two_block();
        logic [511:0] q [$];
        int unsigned k0 = kicks;
        q.push_back(TWO_B1);
        q.push_back(TWO_B2);
        run_message(q, 0, 0);
        tests++;
        if (r_ok !== 1'b1 || r_digest !== TWO_DIG) begin
            fails++;
            $display("FAIL two_digest: got %h expected %h", r_digest, TWO_DIG);
        end
        tests++;
        if (kicks - k0 != 2) begin
            fails++;
            $display("FAIL two_kicks: got %0d expected 2", kicks - k0);
        end
        tests++;
        if (acc_q.size() != 2 || acc_q[1] - acc_q[0] != 67) begin
            fails++;
            $display("FAIL two_block_spacing: got %0d expected 67", (acc_q.size() == 2) ? acc_q[1] - acc_q[0] : 0);
        end
    endtask

    task automatic test_gaps();
        logic [511:0] q [$];
        int gaps [3] = '{0, 5, 20};
        q.push_back(TWO_B1);
        q.push_back(TWO_B2);
        foreach (gaps[g]) begin
            run_message(q, gaps[g], 10);
            tests++;
            if (r_ok !== 1'b1 || r_digest !== TWO_DIG) begin
                fails++;
                $display("FAIL gap%0d_digest: got %h expected %h", gaps[g], r_digest, TWO_DIG);
            end
            tests++;
            if (r_busy_ok !== 1'b1 || r_stable_ok !== 1'b1) begin
                fails++;
                $display("FAIL gap%0d_busy_stable: busy_ok=%0b stable_ok=%0b, expected 1 1", gaps[g], r_busy_ok, r_stable_ok);
            end
        end
    endtask

    task automatic test_ignored_inputs();
        int unsigned k0;
        bit got = 0;
        start = 1'b1; @(negedge clk); start = 1'b0;
        start = 1'b1; @(negedge clk); start = 1'b0;
        tests++;
        if (busy !== 1'b1 || blk_ready !== 1'b1 || dut.H_reg !== IV || dut.blk_cnt !== 16'd0) begin
            fails++;
            $display("FAIL start_in_wait: busy=%0b ready=%0b H_reg=%h, expected 1 1 IV", busy, blk_ready, dut.H_reg);
        end
        force_h = {8{$urandom()}};
        force_cov = 1'b1; @(negedge clk); force_cov = 1'b0;
        tests++;
        if (dut.H_reg !== IV || blk_ready !== 1'b1 || dut.blk_cnt !== 16'd0) begin
            fails++;
            $display("FAIL core_pulse_in_wait: H_reg=%h ready=%0b, expected IV and 1", dut.H_reg, blk_ready);
        end
        k0 = kicks;
        blk_data = ABC_BLK; blk_last = 1'b1; blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0; blk_last = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; blk_valid = 1'b1; blk_data = TWO_B1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        blk_valid = 1'b0;
        tests++;
        if (busy !== 1'b1 || blk_ready !== 1'b0 || kicks - k0 != 1 || core_M_in !== ABC_BLK) begin
            fails++;
            $display("FAIL start_in_run: busy=%0b ready=%0b kicks=%0d, expected 1 0 1", busy, blk_ready, kicks - k0);
        end
        for (int t = 0; t < 200 && !got; t++) begin
            if (digest_valid === 1'b1) got = 1;
            else @(negedge clk);
        end
        tests++;
        if (!got || digest !== ABC_DIG || dut.blk_cnt !== 16'd1) begin
            fails++;
            $display("FAIL ignored_digest: got %h expected %h blk_cnt=%0d", digest, ABC_DIG, dut.blk_cnt);
        end
        digest_ready = 1'b1; @(negedge clk); digest_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [511:0] q [$];
        start = 1'b1; @(negedge clk); start = 1'b0;
        blk_data = ABC_BLK; blk_last = 1'b1; blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0; blk_last = 1'b0;
        repeat (10) @(negedge clk);
        abandoned = 1'b1;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if ({blk_ready, core_H_in, core_M_in, core_input_valid, digest, digest_valid, busy, err} !== '0) begin
                fails++;
                $display("FAIL reset_mid_run_outputs[%0d]: busy=%0b H_in=%h, all required 0", i, busy, core_H_in);
            end
        end
        rst_n = 1'b1;
        repeat (70) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || dut.H_reg !== '0 || digest !== '0 || pend !== 1'b0) begin
            fails++;
            $display("FAIL stale_core_pulse: busy=%0b H_reg=%h digest=%h, expected all 0", busy, dut.H_reg, digest);
        end
        q.push_back(ABC_BLK);
        run_message(q, 0, 0);
        tests++;
        if (r_ok !== 1'b1 || r_digest !== ABC_DIG) begin
            fails++;
            $display("FAIL after_reset_abc: got %h expected %h", r_digest, ABC_DIG);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            logic [511:0] q [$];
            logic [511:0] b;
            logic [255:0] exp_h = IV;
            int nb = $urandom_range(1, 3);
            for (int i = 0; i < nb; i++) begin
                for (int w = 0; w < 16; w++) b[32*w +: 32] = $urandom();
                q.push_back(b);
                exp_h = compress(exp_h, b);
            end
            run_message(q, $urandom_range(0, 7), $urandom_range(0, 4));
            tests++;
            if (r_ok !== 1'b1 || r_digest !== exp_h || r_stable_ok !== 1'b1) begin
                fails++;
                $display("FAIL random%0d_digest: got %h expected %h", n, r_digest, exp_h);
            end
            tests++;
            if (dut.blk_cnt !== 16'(nb)) begin
                fails++;
                $display("FAIL random%0d_blk_cnt: got %0d expected %0d", n, dut.blk_cnt, nb);
            end
        end
    endtask

    task automatic test_hang();
        core_en = 1'b0;
        start = 1'b1; @(negedge clk); start = 1'b0;
        blk_data = ABC_BLK; blk_last = 1'b1; blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0; blk_last = 1'b0;
`ifdef SHA256_SCHED_WDOG_EN
        begin
            int unsigned rise = 0;
            for (int t = 0; t < 150 && rise == 0; t++) begin
                @(negedge clk);
                if (err === 1'b1) rise = cyc;
            end
            tests++;
            if (rise != kick_cyc + 81) begin
                fails++;
                $display("FAIL wdog_err_timing: err rose at edge %0d, expected %0d", rise, kick_cyc + 81);
            end
            start = 1'b1; @(negedge clk); start = 1'b0;
            repeat (20) @(negedge clk);
            tests++;
            if (err !== 1'b1 || busy !== 1'b1) begin
                fails++;
                $display("FAIL wdog_err_sticky: err=%0b busy=%0b, expected 1 1", err, busy);
            end
        end
`else
        repeat (150) @(negedge clk);
        tests++;
        if (err !== 1'b0 || busy !== 1'b1 || digest_valid !== 1'b0 || blk_ready !== 1'b0) begin
            fails++;
            $display("FAIL run_waits: err=%0b busy=%0b dv=%0b, expected 0 1 0", err, busy, digest_valid);
        end
`endif
        rst_n = 1'b0; repeat (2) @(negedge clk); rst_n = 1'b1;
        pend = 1'b0; core_en = 1'b1;
        @(negedge clk);
        tests++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL hang_reset: err=%0b busy=%0b, expected 0 0", err, busy);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_abc();
        test_two_block();
        test_gaps();
        test_ignored_inputs();
        test_reset_mid_run();
        test_random();
        test_hang();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
